// File: rtl/mig_arb_pkg.sv
// Shared types, MIG command opcodes and small helpers for the MIG app-port arbiter.
package mig_arb_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  typedef enum logic [1:0] {
    S_CAL  = 2'd0,
    S_ARB  = 2'd1,
    S_CMD  = 2'd2,
    S_WDAT = 2'd3
  } arb_state_t;

  typedef logic req_id_t;

  function automatic logic [1:0] id_to_onehot(input req_id_t id);
    if (id == 1'b1) begin
      return 2'b10;
    end else begin
      return 2'b01;
    end
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    if (v == 32'hFFFF_FFFF) begin
      return v;
    end else begin
      return v + 32'd1;
    end
  endfunction

endpackage

// File: rtl/mig_tag_fifo.sv
// In-order FIFO of requester ids for outstanding MIG reads, with a show-ahead head.
module mig_tag_fifo
  import mig_arb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output req_id_t head,
  output logic    full,
  output logic    empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  req_id_t     mem_r [DEPTH];
  logic        push_ok_s;
  logic        pop_ok_s;

  // The extra pointer MSB tells a full FIFO from an empty one when the indices match.
  assign empty = (wr_ptr_r == rd_ptr_r);
  assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                 (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);

  assign push_ok_s = push && (!full || pop);
  assign pop_ok_s  = pop && !empty;
  assign head      = mem_r[rd_ptr_r[AW-1:0]];

  // Read/write pointer update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
    end
  end

  // Tag storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= push_id;
    end
  end

endmodule

// File: rtl/mig_app_arb.sv
// Round-robin arbiter of two single-beat requesters onto one MIG native app port.
// Optional per-requester statistics counters: define MIG_APP_ARB_STATS_EN.
module mig_app_arb
  import mig_arb_pkg::*;
#(
  parameter int ADDR_W    = 28,
  parameter int DATA_W    = 128,
  parameter int TAG_DEPTH = 16
) (
  input  logic                sys_clk,
  input  logic                sys_rstn,
  input  logic                init_calib_complete,
  input  logic [1:0]          rq_valid,
  output logic [1:0]          rq_ready,
  input  logic [1:0]          rq_we,
  input  logic [2*ADDR_W-1:0] rq_addr,
  input  logic [2*DATA_W-1:0] rq_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  output logic                rsp_err,
  output logic                app_en,
  output logic [2:0]          app_cmd,
  output logic [ADDR_W-1:0]   app_addr,
  input  logic                app_rdy,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  output logic [DATA_W-1:0]   app_wdf_data,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid
`ifdef MIG_APP_ARB_STATS_EN
  ,
  output logic [63:0]         stat_wr,
  output logic [63:0]         stat_rd
`endif
);

  arb_state_t          state_r;
  arb_state_t          state_s;
  logic                rr_last_r;
  req_id_t             gnt_id_r;
  logic                we_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [1:0]          rsp_valid_r;
  logic [DATA_W-1:0]   rsp_data_r;
  logic                rsp_err_r;

  logic [1:0]          elig_s;
  req_id_t             gnt_s;
  logic                latch_s;
  logic                push_s;
  logic                pop_s;
  logic [1:0]          rq_ready_s;
  logic                app_en_s;
  logic [2:0]          app_cmd_s;
  logic                wren_s;

  logic                fifo_full_s;
  logic                fifo_empty_s;
  req_id_t             fifo_head_s;

  mig_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (sys_clk),
    .rst_n   (sys_rstn),
    .push    (push_s),
    .push_id (gnt_id_r),
    .pop     (pop_s),
    .head    (fifo_head_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Requester eligibility: reads need a free tag slot, writes never do
  always_comb begin
    elig_s    = 2'b00;
    elig_s[0] = rq_valid[0] && (rq_we[0] || !fifo_full_s);
    elig_s[1] = rq_valid[1] && (rq_we[1] || !fifo_full_s);
  end

  // Round-robin pick among eligible requesters
  always_comb begin
    gnt_s = 1'b0;
    if (elig_s == 2'b11) begin
      gnt_s = !rr_last_r;
    end else if (elig_s[0]) begin
      gnt_s = 1'b0;
    end else begin
      gnt_s = 1'b1;
    end
  end

  // FSM state register
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      state_r <= S_CAL;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state and app-port outputs
  always_comb begin
    state_s    = state_r;
    rq_ready_s = 2'b00;
    app_en_s   = 1'b0;
    app_cmd_s  = APP_CMD_WR;
    wren_s     = 1'b0;
    latch_s    = 1'b0;
    push_s     = 1'b0;
    case (state_r)
      S_CAL: begin
        if (init_calib_complete) begin
          state_s = S_ARB;
        end else begin
          state_s = S_CAL;
        end
      end
      S_ARB: begin
        if (elig_s != 2'b00) begin
          rq_ready_s = id_to_onehot(gnt_s);
          latch_s    = 1'b1;
          state_s    = S_CMD;
        end else begin
          state_s = S_ARB;
        end
      end
      S_CMD: begin
        app_en_s  = 1'b1;
        app_cmd_s = we_r ? APP_CMD_WR : APP_CMD_RD;
        if (app_rdy) begin
          if (we_r) begin
            state_s = S_WDAT;
          end else begin
            push_s  = 1'b1;
            state_s = S_ARB;
          end
        end else begin
          state_s = S_CMD;
        end
      end
      S_WDAT: begin
        wren_s = 1'b1;
        if (app_wdf_rdy) begin
          state_s = S_ARB;
        end else begin
          state_s = S_WDAT;
        end
      end
      default: begin
        state_s = S_CAL;
      end
    endcase
  end

  // Capture the granted request so the requester is free after its accept pulse
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rr_last_r <= 1'b1;
      gnt_id_r  <= 1'b0;
      we_r      <= 1'b0;
      addr_r    <= '0;
      wdata_r   <= '0;
    end else if (latch_s) begin
      rr_last_r <= gnt_s;
      gnt_id_r  <= gnt_s;
      we_r      <= rq_we[gnt_s];
      addr_r    <= gnt_s ? rq_addr[ADDR_W +: ADDR_W] : rq_addr[0 +: ADDR_W];
      wdata_r   <= gnt_s ? rq_wdata[DATA_W +: DATA_W] : rq_wdata[0 +: DATA_W];
    end
  end

  assign pop_s = app_rd_data_valid && !fifo_empty_s;

  // Read-return routing; a beat with no outstanding tag is dropped and flagged
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      rsp_valid_r <= 2'b00;
      rsp_data_r  <= '0;
      rsp_err_r   <= 1'b0;
    end else begin
      rsp_valid_r <= 2'b00;
      if (app_rd_data_valid) begin
        if (!fifo_empty_s) begin
          rsp_valid_r <= id_to_onehot(fifo_head_s);
          rsp_data_r  <= app_rd_data;
        end else begin
          rsp_err_r <= 1'b1;
        end
      end
    end
  end

  assign rq_ready     = rq_ready_s;
  assign app_en       = app_en_s;
  assign app_cmd      = app_cmd_s;
  assign app_addr     = addr_r;
  assign app_wdf_wren = wren_s;
  assign app_wdf_end  = wren_s;
  assign app_wdf_data = wdata_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_data     = rsp_data_r;
  assign rsp_err      = rsp_err_r;

`ifdef MIG_APP_ARB_STATS_EN
  logic        cmd_acc_s;
  logic [31:0] stat_wr_r [2];
  logic [31:0] stat_rd_r [2];

  assign cmd_acc_s = (state_r == S_CMD) && app_rdy;

  // Saturating per-requester counts of commands accepted by the MIG
  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      stat_wr_r[0] <= 32'd0;
      stat_wr_r[1] <= 32'd0;
      stat_rd_r[0] <= 32'd0;
      stat_rd_r[1] <= 32'd0;
    end else if (cmd_acc_s) begin
      if (we_r) begin
        stat_wr_r[gnt_id_r] <= sat_inc32(stat_wr_r[gnt_id_r]);
      end else begin
        stat_rd_r[gnt_id_r] <= sat_inc32(stat_rd_r[gnt_id_r]);
      end
    end
  end

  assign stat_wr = {stat_wr_r[1], stat_wr_r[0]};
  assign stat_rd = {stat_rd_r[1], stat_rd_r[0]};
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_mig_app_arb.sv
// Scoreboard bench for mig_app_arb: commands, write data, grants and read responses.
module tb_mig_app_arb;

  localparam logic [2:0] CMD_WR = 3'b000;
  localparam logic [2:0] CMD_RD = 3'b001;

  typedef struct {
    logic [2:0]  cmd;
    logic [27:0] addr;
  } cmd_t;

  typedef struct {
    logic [1:0]   v;
    logic [127:0] d;
    int           cyc;
  } rsp_t;

  logic         clk = 1'b0;
  logic         sys_rstn;
  logic         calib;
  logic [1:0]   rq_valid, rq_ready, rq_we, rsp_valid;
  logic [55:0]  rq_addr;
  logic [255:0] rq_wdata;
  logic [127:0] rsp_data, app_wdf_data, app_rd_data;
  logic         rsp_err, app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy, app_rd_data_valid;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;

  logic         rv [2];
  logic         rwe [2];
  logic [27:0]  raddr [2];
  logic [127:0] rwd [2];
  logic         got [2];
  logic         done [2];

  cmd_t         exp_cmd_q [$];
  logic [127:0] exp_wd_q [$];
  rsp_t         exp_rsp_q [$];
  logic [1:0]   exp_gnt_q [$];
  logic         mdl_tag_q [$];
  logic         gnt_chk_en = 1'b0;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc_cnt = 0;

  assign rq_valid = {rv[1], rv[0]};
  assign rq_we    = {rwe[1], rwe[0]};
  assign rq_addr  = {raddr[1], raddr[0]};
  assign rq_wdata = {rwd[1], rwd[0]};

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  mig_app_arb dut (
    .sys_clk             (clk),
    .sys_rstn            (sys_rstn),
    .init_calib_complete (calib),
    .rq_valid            (rq_valid),
    .rq_ready            (rq_ready),
    .rq_we               (rq_we),
    .rq_addr             (rq_addr),
    .rq_wdata            (rq_wdata),
    .rsp_valid           (rsp_valid),
    .rsp_data            (rsp_data),
    .rsp_err             (rsp_err),
    .app_en              (app_en),
    .app_cmd             (app_cmd),
    .app_addr            (app_addr),
    .app_rdy             (app_rdy),
    .app_wdf_wren        (app_wdf_wren),
    .app_wdf_end         (app_wdf_end),
    .app_wdf_data        (app_wdf_data),
    .app_wdf_rdy         (app_wdf_rdy),
    .app_rd_data         (app_rd_data),
    .app_rd_data_valid   (app_rd_data_valid)
  );

  task automatic check_eq(input string tag, input logic [127:0] got_v, input logic [127:0] exp_v);
    chk_cnt++;
    if (got_v !== exp_v) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got_v, exp_v, cyc_cnt);
    end
  endtask

  // Command scoreboard
  always @(negedge clk) begin
    if (sys_rstn && app_en && app_rdy) begin
      if (exp_cmd_q.size() == 0) begin
        check_eq("cmd_unexpected", 128'd1, 128'd0);
      end else begin
        cmd_t e;
        e = exp_cmd_q.pop_front();
        check_eq("app_cmd", {125'd0, app_cmd}, {125'd0, e.cmd});
        check_eq("app_addr", {100'd0, app_addr}, {100'd0, e.addr});
      end
    end
  end

  // Write-data scoreboard
  always @(negedge clk) begin
    if (sys_rstn && app_wdf_wren && app_wdf_rdy) begin
      if (exp_wd_q.size() == 0) begin
        check_eq("wdf_unexpected", 128'd1, 128'd0);
      end else begin
        check_eq("wdf_data", app_wdf_data, exp_wd_q.pop_front());
        check_eq("wdf_end", {127'd0, app_wdf_end}, 128'd1);
      end
    end
  end

  // Response scoreboard, including the one-cycle latency
  always @(negedge clk) begin
    if (sys_rstn && rsp_valid != 2'b00) begin
      if (exp_rsp_q.size() == 0) begin
        check_eq("rsp_unexpected", {126'd0, rsp_valid}, 128'd0);
      end else begin
        rsp_t r;
        r = exp_rsp_q.pop_front();
        check_eq("rsp_port", {126'd0, rsp_valid}, {126'd0, r.v});
        check_eq("rsp_data", rsp_data, r.d);
        check_eq("rsp_latency", 128'(cyc_cnt), 128'(r.cyc));
      end
    end
  end

  // Grant-order scoreboard, active during the contention tests
  always @(negedge clk) begin
    if (sys_rstn && gnt_chk_en && rq_ready != 2'b00) begin
      if (exp_gnt_q.size() == 0) begin
        check_eq("gnt_unexpected", {126'd0, rq_ready}, 128'd0);
      end else begin
        check_eq("gnt_order", {126'd0, rq_ready}, {126'd0, exp_gnt_q.pop_front()});
      end
    end
  end

  // Caller is at posedge+1; returns at posedge+1 right after the grant edge.
  task automatic req(input int i, input logic we, input logic [27:0] a, input logic [127:0] d);
    int n = 0;
    done[i] = 1'b0;
    got[i] = 1'b0;
    rv[i] = 1'b1;
    rwe[i] = we;
    raddr[i] = a;
    rwd[i] = d;
    while (!got[i] && n < 400) begin
      @(negedge clk);
      if (rq_ready[i]) got[i] = 1'b1;
      n++;
    end
    if (!got[i]) check_eq("grant_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
    rv[i] = 1'b0;
    done[i] = 1'b1;
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    while (!done[i] && n < 500) begin
      @(posedge clk);
      n++;
    end
    if (!done[i]) check_eq("done_timeout", 128'd0, 128'd1);
    @(posedge clk);
    #1;
  endtask

  // Drives one read beat for one cycle (caller at posedge+1, leaves valid high).
  task automatic beat(input logic [127:0] d);
    rsp_t r;
    app_rd_data_valid = 1'b1;
    app_rd_data = d;
    if (mdl_tag_q.size() > 0) begin
      r.v = mdl_tag_q.pop_front() ? 2'b10 : 2'b01;
      r.d = d;
      r.cyc = cyc_cnt + 1;
      exp_rsp_q.push_back(r);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic beat_end();
    app_rd_data_valid = 1'b0;
  endtask

  task automatic push_rd(input int i, input logic [27:0] a);
    cmd_t c;
    c.cmd = CMD_RD;
    c.addr = a;
    exp_cmd_q.push_back(c);
    mdl_tag_q.push_back(i[0]);
  endtask

  task automatic push_wr(input logic [27:0] a, input logic [127:0] d);
    cmd_t c;
    c.cmd = CMD_WR;
    c.addr = a;
    exp_cmd_q.push_back(c);
    exp_wd_q.push_back(d);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad, en_cnt, wr_cnt, en_wdat, first;
    logic [127:0] dead;
    dead = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_CAFE_F00D;
    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0; rwe[i] = 1'b0; raddr[i] = 28'd0; rwd[i] = 128'd0;
      got[i] = 1'b0; done[i] = 1'b0;
    end
    sys_rstn = 1'b0; calib = 1'b0; app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = 128'd0; app_rd_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 sys_rstn = 1'b1;

    // Reset state
    @(negedge clk);
    check_eq("rst_rq_ready", {126'd0, rq_ready}, 128'd0);
    check_eq("rst_app_en", {127'd0, app_en}, 128'd0);
    check_eq("rst_wdf_wren", {127'd0, app_wdf_wren}, 128'd0);
    check_eq("rst_rsp_valid", {126'd0, rsp_valid}, 128'd0);
    check_eq("rst_rsp_err", {127'd0, rsp_err}, 128'd0);

    // Calibration gate
    @(posedge clk); #1;
    push_rd(0, 28'h40);
    fork req(0, 1'b0, 28'h40, 128'd0); join_none
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (rq_ready != 2'b00 || app_en) bad++;
    end
    check_eq("calib_gate", 128'(bad), 128'd0);
    @(posedge clk); #1 calib = 1'b1;
    n = 0;
    while (n < 5) begin
      @(negedge clk);
      n++;
      if (rq_ready[0]) break;
    end
    check_eq("calib_latency_ok", {127'd0, n <= 2}, 128'd1);
    wait_done(0);
    beat({4{32'h0C0C_0001}});
    beat_end();

    // Round robin: requester 0 won last, so requester 1 goes first
    first = 1;
    for (int k = 0; k < 16; k++) begin
      int g;
      g = (first + k) % 2;
      push_rd(g, (g == 1 ? 28'h2000 : 28'h1000) + 28'(k / 2));
      exp_gnt_q.push_back(g == 1 ? 2'b10 : 2'b01);
    end
    gnt_chk_en = 1'b1;
    fork
      begin
        for (int k = 0; k < 8; k++) req(0, 1'b0, 28'h1000 + 28'(k), 128'd0);
      end
      begin
        for (int k = 0; k < 8; k++) req(1, 1'b0, 28'h2000 + 28'(k), 128'd0);
      end
    join
    gnt_chk_en = 1'b0;
    check_eq("rr_all_granted", 128'(exp_gnt_q.size()), 128'd0);
    for (int k = 0; k < 16; k++) beat({96'h0, 32'hBEEF_0000 + 32'(k)});
    beat_end();

    // Write path with app_rdy and app_wdf_rdy stalls
    app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    push_wr(28'h100, dead);
    req(1, 1'b1, 28'h100, dead);
    en_cnt = 0; wr_cnt = 0; en_wdat = 0;
    repeat (5) begin @(negedge clk); if (app_en) en_cnt++; end
    @(posedge clk); #1 app_rdy = 1'b1;
    @(negedge clk); if (app_en) en_cnt++;
    @(posedge clk); #1 app_rdy = 1'b0;
    repeat (3) begin @(negedge clk); if (app_wdf_wren) wr_cnt++; if (app_en) en_wdat++; end
    @(posedge clk); #1 app_wdf_rdy = 1'b1;
    @(negedge clk); if (app_wdf_wren) wr_cnt++;
    @(posedge clk); #1 app_rdy = 1'b1;
    @(negedge clk);
    check_eq("wr_app_en_cycles", 128'(en_cnt), 128'd6);
    check_eq("wr_wdf_cycles", 128'(wr_cnt), 128'd4);
    check_eq("wr_no_en_in_wdat", 128'(en_wdat), 128'd0);
    check_eq("wr_wdf_released", {127'd0, app_wdf_wren}, 128'd0);
    @(posedge clk); #1;

    // Read routing r0, r1, r1, r0
    push_rd(0, 28'h400); req(0, 1'b0, 28'h400, 128'd0);
    push_rd(1, 28'h401); req(1, 1'b0, 28'h401, 128'd0);
    push_rd(1, 28'h402); req(1, 1'b0, 28'h402, 128'd0);
    push_rd(0, 28'h403); req(0, 1'b0, 28'h403, 128'd0);
    repeat (2) @(posedge clk); #1;
    beat({4{32'hAAAA_0001}});
    beat({4{32'hBBBB_0002}});
    beat({4{32'hCCCC_0003}});
    beat({4{32'hDDDD_0004}});
    beat_end();

    // Full tag FIFO blocks reads but not writes
    for (int k = 0; k < 16; k++) begin
      push_rd(0, 28'h3000 + 28'(k));
      req(0, 1'b0, 28'h3000 + 28'(k), 128'd0);
    end
    push_wr(28'h200, {4{32'h5A5A_A5A5}});
    push_rd(0, 28'h3100);
    fork req(0, 1'b0, 28'h3100, 128'd0); join_none
    req(1, 1'b1, 28'h200, {4{32'h5A5A_A5A5}});
    repeat (10) @(negedge clk);
    check_eq("full_read_blocked", {127'd0, got[0]}, 128'd0);
    @(posedge clk); #1;
    beat({4{32'h1111_0000}});
    beat_end();
    wait_done(0);
    check_eq("full_read_released", {127'd0, got[0]}, 128'd1);
    repeat (2) @(posedge clk); #1;
    for (int k = 0; k < 16; k++) beat({96'h0, 32'h2222_0000 + 32'(k)});
    beat_end();
    repeat (3) @(posedge clk); #1;

    // Stray read data with nothing outstanding
    @(negedge clk);
    check_eq("err_before", {127'd0, rsp_err}, 128'd0);
    @(posedge clk); #1;
    beat({4{32'hBAD0_BAD0}});
    beat_end();
    @(negedge clk);
    check_eq("err_set", {127'd0, rsp_err}, 128'd1);
    check_eq("err_no_rsp", {126'd0, rsp_valid}, 128'd0);
    repeat (3) @(negedge clk);
    check_eq("err_sticky", {127'd0, rsp_err}, 128'd1);

    // Reset while a command is held in S_CMD
    @(posedge clk); #1 app_rdy = 1'b0;
    req(0, 1'b0, 28'h500, 128'd0);
    @(negedge clk);
    check_eq("held_app_en", {127'd0, app_en}, 128'd1);
    #1 sys_rstn = 1'b0;
    #1;
    check_eq("rst_mid_app_en", {127'd0, app_en}, 128'd0);
    check_eq("rst_mid_rsp_err", {127'd0, rsp_err}, 128'd0);
    repeat (2) @(posedge clk);
    #1 sys_rstn = 1'b1; app_rdy = 1'b1;

    // After reset requester 0 wins the first tie again
    push_rd(0, 28'h600); push_rd(1, 28'h700);
    exp_gnt_q.push_back(2'b01); exp_gnt_q.push_back(2'b10);
    gnt_chk_en = 1'b1;
    fork
      req(0, 1'b0, 28'h600, 128'd0);
      req(1, 1'b0, 28'h700, 128'd0);
    join
    gnt_chk_en = 1'b0;
    repeat (2) @(posedge clk); #1;
    beat({4{32'h6666_0000}});
    beat({4{32'h7777_0000}});
    beat_end();
    repeat (4) @(posedge clk);

    check_eq("sb_cmd_empty", 128'(exp_cmd_q.size()), 128'd0);
    check_eq("sb_wdf_empty", 128'(exp_wd_q.size()), 128'd0);
    check_eq("sb_rsp_empty", 128'(exp_rsp_q.size()), 128'd0);
    check_eq("sb_gnt_empty", 128'(exp_gnt_q.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
